// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - Galois LFSR random-word generator with valid/ready output and reseed
// Optional build macro: LFSR_RNG_REJECT_EN (discard completed words >= RANGE)
module lfsr_rng #(
  parameter int               WIDTH    = 31,
  parameter logic [WIDTH-1:0] TAPS     = 31'h0800_0000,
  parameter logic [WIDTH-1:0] SEED     = 31'h1,
  parameter int               OUT_BITS = 8,
  parameter int               RANGE    = 7
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  input  logic                rand_ready,
  output logic                rand_valid,
  output logic [OUT_BITS-1:0] rand_data,
  output logic [WIDTH-1:0]    lfsr_state
);

  // Bit counter must hold 0..OUT_BITS-1; keep at least one bit for OUT_BITS=1.
  localparam int                CW      = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0]     LAST    = CW'(OUT_BITS - 1);
  localparam logic [OUT_BITS:0] RANGE_W = (OUT_BITS + 1)'(RANGE);

`ifdef LFSR_RNG_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    lfsr_q;
  logic [OUT_BITS-1:0] word_q;
  logic                valid_q;

  logic [WIDTH-1:0]    lfsr_step;
  logic [OUT_BITS-1:0] word_next;
  logic                word_ok;

  // One right-shifting Galois step; the bit leaving stage 0 feeds the top stage and the tapped stages.
  always_comb begin
    lfsr_step = {lfsr_q[0], lfsr_q[WIDTH-1:1] ^ (TAPS[WIDTH-2:0] & {(WIDTH-1){lfsr_q[0]}})};
  end

  // Word with this step's output bit placed at position cnt (word is cleared at the start of every fill).
  always_comb begin
    word_next = word_q | (OUT_BITS'(lfsr_q[0]) << cnt);
    word_ok   = !REJECT_EN || ({1'b0, word_next} < RANGE_W);
  end

  // Fill/present state machine; reseed overrides everything except reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      lfsr_q  <= SEED;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
      state   <= FILL;
    end else if (seed_load) begin
      // An all-zero state would lock the LFSR, so it is replaced by 1.
      lfsr_q  <= (seed == '0) ? WIDTH'(1) : seed;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
      state   <= FILL;
    end else begin
      case (state)
        FILL: begin
          lfsr_q <= lfsr_step;
          if (cnt == LAST) begin
            cnt <= '0;
            if (word_ok) begin
              word_q  <= word_next;
              valid_q <= 1'b1;
              state   <= VALID;
            end else begin
              word_q <= '0;
            end
          end else begin
            cnt    <= cnt + CW'(1);
            word_q <= word_next;
          end
        end
        VALID: begin
          if (rand_ready) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign rand_valid = valid_q;
  assign rand_data  = word_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - directed self-checking bench for lfsr_rng
module tb_lfsr_rng;

  logic        clk;
  logic        rst_l;

  logic        seed_load;
  logic [30:0] seed;
  logic        rand_ready;
  logic        rand_valid;
  logic [7:0]  rand_data;
  logic [30:0] lfsr_state;

  logic        s4_load;
  logic [3:0]  s4_seed;
  logic        ready4;
  logic        valid4;
  logic [0:0]  data4;
  logic [3:0]  lfsr4;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  lfsr_rng dut (
    .clk(clk), .rst_l(rst_l), .seed_load(seed_load), .seed(seed),
    .rand_ready(rand_ready), .rand_valid(rand_valid), .rand_data(rand_data),
    .lfsr_state(lfsr_state)
  );

  lfsr_rng #(.WIDTH(4), .TAPS(4'h4), .SEED(4'h1), .OUT_BITS(1)) dut4 (
    .clk(clk), .rst_l(rst_l), .seed_load(s4_load), .seed(s4_seed),
    .rand_ready(ready4), .rand_valid(valid4), .rand_data(data4),
    .lfsr_state(lfsr4)
  );

`ifdef LFSR_RNG_REJECT_EN
  logic        s3_load;
  logic [30:0] s3_seed;
  logic        ready3;
  logic        valid3;
  logic [2:0]  data3;
  logic [30:0] lfsr3;

  lfsr_rng #(.OUT_BITS(3), .RANGE(7)) dut3 (
    .clk(clk), .rst_l(rst_l), .seed_load(s3_load), .seed(s3_seed),
    .rand_ready(ready3), .rand_valid(valid3), .rand_data(data3),
    .lfsr_state(lfsr3)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_l && rand_valid && rand_ready) xfers <= xfers + 1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rand_valid && n < bound);
  endtask

  task automatic wait_valid4(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid4 && n < bound);
  endtask

  initial begin
    int n;
    int x0;
    bit stable;
    logic [3:0] prev;
    logic [3:0] exp4 [16];

    exp4 = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC};

    rst_l = 1'b0; seed_load = 1'b0; seed = '0; rand_ready = 1'b0;
    s4_load = 1'b0; s4_seed = '0; ready4 = 1'b1;
`ifdef LFSR_RNG_REJECT_EN
    s3_load = 1'b0; s3_seed = '0; ready3 = 1'b1;
`endif
    @(negedge clk);
    tick();
    tick();

`ifdef LFSR_RNG_REJECT_EN
    begin
      int hist [7];
      int words;
      bit in_range;
      bit timeout;
      for (int v = 0; v < 7; v++) hist[v] = 0;
      in_range = 1'b1;
      timeout  = 1'b0;
      words    = 0;
      rst_l = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!valid3 && n < 64);
      check("rej_first_valid", valid3, 1);
      check("rej_first_word", data3, 1);
      while (words < 10000 && !timeout) begin
        if (data3 >= 3'd7) in_range = 1'b0;
        else hist[data3]++;
        words++;
        n = 0;
        do begin tick(); n++; end while (!valid3 && n < 64);
        if (!valid3) timeout = 1'b1;
      end
      check("rej_timeout", timeout, 0);
      check("rej_in_range", in_range, 1);
      for (int v = 0; v < 7; v++)
        check($sformatf("rej_hist_%0d", v), (hist[v] >= 1286 && hist[v] <= 1572), 1);
    end
`else
    // reset state
    check("rst_lfsr", lfsr_state, 32'h1);
    check("rst_valid", rand_valid, 0);
    check("rst_data", rand_data, 0);

    // continuous ready: latency and first four words
    rand_ready = 1'b1;
    rst_l = 1'b1;
    wait_valid(30, n);
    check("w0_latency", n, 8);
    check("w0_data", rand_data, 8'h01);
    check("w0_lfsr", lfsr_state, 32'h0090_0000);
    wait_valid(30, n);
    check("w1_period", n, 9);
    check("w1_data", rand_data, 8'h00);
    wait_valid(30, n);
    check("w2_period", n, 9);
    check("w2_data", rand_data, 8'h00);
    wait_valid(30, n);
    check("w3_period", n, 9);
    check("w3_data", rand_data, 8'h90);

    // backpressure: hold ready low for 20 cycles in VALID
    rst_l = 1'b0; rand_ready = 1'b0;
    tick(); tick();
    rst_l = 1'b1;
    wait_valid(30, n);
    check("bp_latency", n, 8);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(rand_valid === 1'b1 && rand_data === 8'h01 && lfsr_state === 31'h0090_0000)) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    x0 = xfers;
    rand_ready = 1'b1;
    tick();
    rand_ready = 1'b0;
    check("bp_one_xfer", xfers - x0, 1);
    check("bp_valid_drop", rand_valid, 0);
    wait_valid(30, n);
    check("bp_refill", n, 8);
    check("bp_next_data", rand_data, 8'h00);

    // reset while VALID discards the word
    rst_l = 1'b0;
    tick();
    check("rstv_valid", rand_valid, 0);
    check("rstv_lfsr", lfsr_state, 32'h1);
    check("rstv_data", rand_data, 0);
    rst_l = 1'b1;

    // zero seed mid-fill
    tick(); tick(); tick();
    seed_load = 1'b1; seed = 31'h0;
    tick();
    seed_load = 1'b0;
    check("zs_lfsr", lfsr_state, 32'h1);
    check("zs_valid", rand_valid, 0);
    check("zs_data", rand_data, 0);
    wait_valid(30, n);
    check("zs_latency", n, 8);
    check("zs_word", rand_data, 8'h01);

    // reseed coincident with a transfer
    x0 = xfers;
    rand_ready = 1'b1; seed_load = 1'b1; seed = 31'h1234_5678;
    tick();
    seed_load = 1'b0; rand_ready = 1'b0;
    check("sx_lfsr", lfsr_state, 32'h1234_5678);
    check("sx_valid", rand_valid, 0);
    check("sx_xfer", xfers - x0, 1);
    wait_valid(30, n);
    check("sx_latency", n, 8);
    check("sx_word", rand_data, 8'h78);
    check("sx_xfer_once", xfers - x0, 1);

    // 4-bit maximal-length LFSR, one bit per word
    rst_l = 1'b0;
    tick(); tick();
    check("w4_rst_lfsr", lfsr4, 32'h1);
    check("w4_rst_valid", valid4, 0);
    rst_l = 1'b1;
    prev = 4'h1;
    for (int i = 0; i < 16; i++) begin
      wait_valid4(4, n);
      check($sformatf("w4_valid_%0d", i), valid4, 1);
      check($sformatf("w4_state_%0d", i), lfsr4, exp4[i]);
      check($sformatf("w4_bit_%0d", i), data4, prev[0]);
      prev = exp4[i];
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised Galois LFSR random-word generator; successor to the fixed 31-bit single-bit LFSR.
- Advances the LFSR one step per cycle and collects OUT_BITS output bits into a word.
- Presents each word over a valid/ready handshake. Supports runtime reseed with zero-lock protection.
- Sits between the game logic's next-piece queue and the rest of the design, e.g. OUT_BITS=3 to supply tetromino indices.

Parameters:
- WIDTH, 31: LFSR length in bits; must be ≥2.
- TAPS, 31'h0800_0000: Galois XOR mask, right-shift form. Bit i set means stage i receives the feedback XOR. Default implements x^31+x^28+1.
- SEED, 31'h1: reset state of the LFSR; must be nonzero.
- OUT_BITS, 8: bits per output word, 1..WIDTH.
- RANGE, 7: exclusive upper bound on accepted words. Used only with LFSR_RNG_REJECT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_l  in  1  reset; synchronous, active-low.
- seed_load  in  1  one-cycle strobe; reload the LFSR from seed.
- seed  in  WIDTH  new LFSR state, sampled when seed_load=1.
- rand_ready  in  1  consumer accepts rand_data.
- rand_valid  out  1  rand_data holds a complete word.
- rand_data  out  OUT_BITS  random word.
- lfsr_state  out  WIDTH  current LFSR register contents (debug).

Behaviour:
- LFSR step, from s to n:
  - n[WIDTH-1] = s[0]
  - n[i] = s[i+1] ^ (TAPS[i] & s[0]) for i < WIDTH-1
  - The output bit of a step is s[0], taken before the update.
- States:
  - FILL: step every cycle and shift the output bit into the word. The first bit of a word lands in rand_data[0], the k-th in rand_data[k]. The bit counter runs 0..OUT_BITS-1; after the step at count OUT_BITS-1, go to VALID.
  - VALID: rand_valid=1. LFSR frozen, rand_data stable. On rand_valid & rand_ready, transfer occurs; go to FILL next cycle with the counter cleared.
- The LFSR advances only in FILL. Throughput: one word per OUT_BITS+1 cycles under continuous ready.
- Reset (rst_l=0 at a clock edge):
  - lfsr_state=SEED, rand_data=0, rand_valid=0, counter=0, state=FILL.
  - First rand_valid is asserted OUT_BITS cycles after the first edge with rst_l=1.
  - Reset mid-fill or mid-VALID aborts everything; the pending word is lost.
- seed_load=1 has priority over FILL/VALID activity in any state:
  - lfsr_state = seed, or all-zero seed replaced by WIDTH'h1 (zero-lock guard).
  - Counter cleared, rand_data cleared, rand_valid=0, state=FILL.
  - No LFSR step occurs in the load cycle.
- seed_load together with rand_valid & rand_ready: the transfer counts as completed, then the reseed applies.
- rand_ready while in FILL is ignored. rand_valid never drops without a transfer, except on reset or seed_load.
- The all-zero LFSR state is unreachable.

Optional Feature:
- LFSR_RNG_REJECT_EN defined: on word completion, if the word ≥ RANGE, discard it silently. Counter clears, state stays FILL, and the LFSR keeps stepping. Only words < RANGE reach VALID, giving a uniform distribution on 0..RANGE-1. Requires 1 ≤ RANGE ≤ 2^OUT_BITS.
- LFSR_RNG_REJECT_EN undefined: RANGE is ignored and every completed word is presented.

Test Plan:
- Defaults, ready held 1 after reset: first four transferred words are 8'h01, 8'h00, 8'h00, 8'h90. rand_valid first high 8 cycles after reset release; transfers every 9 cycles.
- Hold rand_ready=0 for 20 cycles in VALID: rand_data stays 8'h01, lfsr_state unchanged. Raise ready: one transfer, then valid low for 8 cycles.
- seed_load with seed=0 mid-fill: lfsr_state=31'h1 next cycle, rand_valid=0. Next word is 8'h01 after 8 cycles.
- seed_load coincident with rand_valid & rand_ready: word counted as transferred once, LFSR equals seed, valid low for OUT_BITS cycles.
- WIDTH=4, TAPS=4'h4 (x^4+x^3+1), OUT_BITS=1, SEED=1: lfsr_state visits all 15 nonzero states before repeating; never 0.
- LFSR_RNG_REJECT_EN, OUT_BITS=3, RANGE=7: 10000 words all in 0..6, each value count within ±10% of 1429. First word 3'd1.
